// File: rtl/sprite_compositor_pkg.sv
// Shared types and default constants for the sprite compositor.
package sprite_compositor_pkg;

  localparam int unsigned RGB_W   = 9;
  localparam int unsigned COORD_W = 10;
  localparam int unsigned SUM_W   = 11;

  localparam logic [RGB_W-1:0] TRANSPARENT_DEF = 9'b111000111;
  localparam logic [RGB_W-1:0] BG_DEF          = 9'b000000000;

  // RGB333 pixel, red in the top bits.
  typedef struct packed {
    logic [2:0] red;
    logic [2:0] grn;
    logic [2:0] blu;
  } rgb333_t;

  // Which layer wins the final pixel.
  typedef enum logic [1:0] {
    SEL_BLANK,
    SEL_BG,
    SEL_FROG,
    SEL_CAR
  } layer_e;

  // True when a sprite pixel is the colour key and must show the layer below.
  function automatic logic is_key(input logic [RGB_W-1:0] pix, input logic [RGB_W-1:0] key);
    return pix == key;
  endfunction

endpackage

// File: rtl/sprite_compositor_rom.sv
// Synchronous-read sprite ROM; contents are a fixed procedural pattern.
// Frog: top half opaque {7, dy[2:0], 0,dx[1:0]}, bottom half colour key.
// Car : {2'b01, dy[1:0], dx[4:0]}, never equal to the key (bit 8 is 0).
module sprite_compositor_rom
  import sprite_compositor_pkg::*;
#(
  parameter int unsigned      TILE_W      = 5,
  parameter bit               IS_FROG     = 1'b1,
  parameter logic [RGB_W-1:0] TRANSPARENT = TRANSPARENT_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [2*TILE_W-1:0]   addr_i,
  output logic [RGB_W-1:0]      data_o
);

  logic [TILE_W-1:0] dx;
  logic [TILE_W-1:0] dy;
  logic [RGB_W-1:0]  pix_d;
  logic [RGB_W-1:0]  data_q;

  assign dx = addr_i[TILE_W-1:0];
  assign dy = addr_i[2*TILE_W-1:TILE_W];

  // Pattern lookup for the addressed texel.
  always_comb begin
    pix_d = '0;
    if (IS_FROG) begin
      pix_d = dy[TILE_W-1] ? TRANSPARENT : {3'b111, 3'(dy), 1'b0, 2'(dx)};
    end else begin
      pix_d = {2'b01, 2'(dy), 5'(dx)};
    end
  end

  // One-cycle registered read.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) data_q <= '0;
    else       data_q <= pix_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/sprite_compositor.sv
// Three-stage frog + lane-car renderer with frame-latched positions.
module sprite_compositor
  import sprite_compositor_pkg::*;
#(
  parameter int unsigned      TILE_SIZE      = 32,
  parameter int unsigned      NUM_CARS       = 4,
  parameter int unsigned      LANE_Y0        = 64,
  parameter int unsigned      LANE_PITCH     = 64,
  parameter int unsigned      H_VISIBLE_AREA = 640,
  parameter int unsigned      V_VISIBLE_AREA = 480,
  parameter logic [RGB_W-1:0] TRANSPARENT    = TRANSPARENT_DEF,
  parameter logic [RGB_W-1:0] BG_COLOUR      = BG_DEF
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst,
  input  logic [COORD_W-1:0]        i_H_Counter,
  input  logic [COORD_W-1:0]        i_V_Counter,
  input  logic [COORD_W-1:0]        i_Frog_X,
  input  logic [8:0]                i_Frog_Y,
  input  logic                      i_Frog_En,
  input  logic [10*NUM_CARS-1:0]    i_Car_X,
  input  logic [NUM_CARS-1:0]       i_Reverse,
  output logic [2:0]                o_Red,
  output logic [2:0]                o_Grn,
  output logic [2:0]                o_Blu,
  output logic                      o_Active
);

  localparam int unsigned TILE_W = $clog2(TILE_SIZE);
  localparam int unsigned ADDR_W = 2 * TILE_W;
  localparam int unsigned CIDX_W = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;

  // Frame-latched positions.
  logic [COORD_W-1:0]     frog_x_q;
  logic [8:0]             frog_y_q;
  logic                   frog_en_q;
  logic [10*NUM_CARS-1:0] car_x_q;
  logic [NUM_CARS-1:0]    rev_q;
  logic                   armed_q;
  logic                   capture_c;

  assign capture_c = (i_H_Counter == '0) && (i_V_Counter == COORD_W'(V_VISIBLE_AREA));

  // Capture game positions on the first blanking line; arms drawing.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      frog_x_q  <= '0;
      frog_y_q  <= '0;
      frog_en_q <= 1'b0;
      car_x_q   <= '0;
      rev_q     <= '0;
      armed_q   <= 1'b0;
    end else if (capture_c) begin
      frog_x_q  <= i_Frog_X;
      frog_y_q  <= i_Frog_Y;
      frog_en_q <= i_Frog_En;
      car_x_q   <= i_Car_X;
      rev_q     <= i_Reverse;
      armed_q   <= 1'b1;
    end
  end

  // S0: visibility, hit tests and ROM addresses (11-bit sums, no wrap).
  logic [SUM_W-1:0]  h_ext, v_ext, fx, fy;
  logic              visible_c, frog_hit_c, car_hit_c;
  logic [TILE_W-1:0] frog_dx, frog_dy;
  logic [ADDR_W-1:0] frog_addr_c, car_addr_c;
  logic [CIDX_W-1:0] car_idx_c;
  logic [NUM_CARS-1:0] lane_hit;
  logic [ADDR_W-1:0] lane_addr [NUM_CARS];

  assign h_ext     = {1'b0, i_H_Counter};
  assign v_ext     = {1'b0, i_V_Counter};
  assign fx        = {1'b0, frog_x_q};
  assign fy        = {2'b00, frog_y_q};
  assign visible_c = (i_H_Counter < COORD_W'(H_VISIBLE_AREA)) &&
                     (i_V_Counter < COORD_W'(V_VISIBLE_AREA));
  assign frog_hit_c = armed_q && frog_en_q &&
                      (h_ext >= fx) && (h_ext < fx + SUM_W'(TILE_SIZE)) &&
                      (v_ext >= fy) && (v_ext < fy + SUM_W'(TILE_SIZE));
  assign frog_dx     = TILE_W'(h_ext - fx);
  assign frog_dy     = TILE_W'(v_ext - fy);
  assign frog_addr_c = {frog_dy, frog_dx};

  for (genvar k = 0; k < NUM_CARS; k++) begin : g_lane
    localparam logic [SUM_W-1:0] LANE_Y = SUM_W'(LANE_Y0 + k * LANE_PITCH);
    logic [SUM_W-1:0]  cx;
    logic [TILE_W-1:0] dx, dy;
    assign cx = {1'b0, car_x_q[10*k +: 10]};
    assign dx = TILE_W'(h_ext - cx);
    assign dy = TILE_W'(v_ext - LANE_Y);
    assign lane_hit[k]  = (h_ext >= cx) && (h_ext < cx + SUM_W'(TILE_SIZE)) &&
                          (v_ext >= LANE_Y) && (v_ext < LANE_Y + SUM_W'(TILE_SIZE));
    assign lane_addr[k] = {dy, rev_q[k] ? ~dx : dx};
  end

  // Lanes are disjoint, so at most one car hits; encode it and pick its address.
  always_comb begin
    car_hit_c = 1'b0;
    car_idx_c = '0;
    for (int k = 0; k < NUM_CARS; k++) begin
      if (lane_hit[k]) begin
        car_hit_c = armed_q;
        car_idx_c = CIDX_W'(k);
      end
    end
    car_addr_c = lane_addr[car_idx_c];
  end

  // S0 -> S1 and S1 -> S2 registers; flags ride alongside the ROM read.
  logic [ADDR_W-1:0] frog_addr_q, car_addr_q;
  logic vis_s1_q, frog_hit_s1_q, car_hit_s1_q;
  logic vis_s2_q, frog_hit_s2_q, car_hit_s2_q;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      frog_addr_q   <= '0;
      car_addr_q    <= '0;
      vis_s1_q      <= 1'b0;
      frog_hit_s1_q <= 1'b0;
      car_hit_s1_q  <= 1'b0;
      vis_s2_q      <= 1'b0;
      frog_hit_s2_q <= 1'b0;
      car_hit_s2_q  <= 1'b0;
    end else begin
      frog_addr_q   <= frog_addr_c;
      car_addr_q    <= car_addr_c;
      vis_s1_q      <= visible_c;
      frog_hit_s1_q <= frog_hit_c;
      car_hit_s1_q  <= car_hit_c;
      vis_s2_q      <= vis_s1_q;
      frog_hit_s2_q <= frog_hit_s1_q;
      car_hit_s2_q  <= car_hit_s1_q;
    end
  end

  logic [RGB_W-1:0] frog_pix, car_pix;

  sprite_compositor_rom #(
    .TILE_W(TILE_W), .IS_FROG(1'b1), .TRANSPARENT(TRANSPARENT)
  ) u_frog_rom (
    .clk_i(i_Clk), .rst_i(i_Rst), .addr_i(frog_addr_q), .data_o(frog_pix)
  );

  sprite_compositor_rom #(
    .TILE_W(TILE_W), .IS_FROG(1'b0), .TRANSPARENT(TRANSPARENT)
  ) u_car_rom (
    .clk_i(i_Clk), .rst_i(i_Rst), .addr_i(car_addr_q), .data_o(car_pix)
  );

  // S2: layer select, frog above car above background.
  layer_e  sel_c;
  rgb333_t rgb_d, rgb_q;
  logic    active_d, active_q;

  always_comb begin
    sel_c    = SEL_BLANK;
    rgb_d    = '0;
    active_d = 1'b0;
    if (vis_s2_q) begin
      active_d = 1'b1;
      if (frog_hit_s2_q && !is_key(frog_pix, TRANSPARENT))     sel_c = SEL_FROG;
      else if (car_hit_s2_q && !is_key(car_pix, TRANSPARENT))  sel_c = SEL_CAR;
      else                                                     sel_c = SEL_BG;
    end
    case (sel_c)
      SEL_FROG: rgb_d = rgb333_t'(frog_pix);
      SEL_CAR:  rgb_d = rgb333_t'(car_pix);
      SEL_BG:   rgb_d = rgb333_t'(BG_COLOUR);
      default:  rgb_d = '0;
    endcase
  end

  // Registered colour outputs.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      rgb_q    <= '0;
      active_q <= 1'b0;
    end else begin
      rgb_q    <= rgb_d;
      active_q <= active_d;
    end
  end

  assign o_Red    = rgb_q.red;
  assign o_Grn    = rgb_q.grn;
  assign o_Blu    = rgb_q.blu;
  assign o_Active = active_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench for sprite_compositor: stimulus queues expected pixels, monitor compares.
module tb_sprite_compositor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  h_cnt = '0;
  logic [9:0]  v_cnt = '0;
  logic [9:0]  frog_x = '0;
  logic [8:0]  frog_y = '0;
  logic        frog_en = 1'b0;
  logic [39:0] car_x = '0;
  logic [3:0]  rev = '0;
  logic [2:0]  red, grn, blu;
  logic        active;

  sprite_compositor dut (
    .i_Clk(clk), .i_Rst(rst), .i_H_Counter(h_cnt), .i_V_Counter(v_cnt),
    .i_Frog_X(frog_x), .i_Frog_Y(frog_y), .i_Frog_En(frog_en),
    .i_Car_X(car_x), .i_Reverse(rev),
    .o_Red(red), .o_Grn(grn), .o_Blu(blu), .o_Active(active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [9:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [9:0] dut_out;
  assign dut_out = {active, red, grn, blu};

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got active=%0b rgb=%03h, want active=%0b rgb=%03h",
                  name, act[9], act[8:0], exp[9], exp[8:0]);
  endtask

  // Present one (H,V) and queue the pixel expected three clocks later.
  task automatic drive(input int h, input int v, input logic act,
                       input logic [8:0] rgb, input string name);
    exp_t e;
    @(negedge clk);
    h_cnt  = 10'(h);
    v_cnt  = 10'(v);
    e.due  = cyc + 3;
    e.exp  = {act, rgb};
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d pixels never compared, want 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: the DUT presents a pixel every clock; compare the one due now.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.due == cyc) check(mon_e.name, dut_out, mon_e.exp);
      else begin
        n_checks++;
        $display("FAIL %s: slot %0d missed at cycle %0d", mon_e.name, mon_e.due, cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    frog_x  = 10'd100;
    frog_y  = 9'd200;
    frog_en = 1'b1;
    car_x   = '0;
    rev     = '0;
    #1;
    check("reset_state", dut_out, 10'h000);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Not armed yet: background only.
    drive(100, 200, 1'b1, 9'h000, "pre_arm_frog");
    drive(0,   64,  1'b1, 9'h000, "pre_arm_car0");
    drive(0,   480, 1'b0, 9'h000, "capture1");

    // Frog at (100,200), all cars at X=0, no mirroring.
    drive(100, 200, 1'b1, 9'h1C0, "frog_px00");
    drive(105, 203, 1'b1, 9'h1D9, "frog_px5_3");
    drive(131, 200, 1'b1, 9'h1C3, "frog_right_col");
    drive(132, 200, 1'b1, 9'h000, "frog_right_out");
    drive(100, 216, 1'b1, 9'h000, "frog_key_bg");
    drive(0,   64,  1'b1, 9'h080, "car0_px00");
    drive(31,  65,  1'b1, 9'h0BF, "car0_px31_1");
    drive(32,  64,  1'b1, 9'h000, "car0_right_out");
    drive(100, 199, 1'b1, 9'h000, "frog_above");

    // Frog over car 0; car 1 at X=300 mirrored.
    frog_x = 10'd0;
    frog_y = 9'd64;
    car_x  = {10'd0, 10'd0, 10'd300, 10'd0};
    rev    = 4'b0010;
    drive(0,   480, 1'b0, 9'h000, "capture2");
    drive(300, 128, 1'b1, 9'h09F, "car1_rev_left");
    drive(331, 128, 1'b1, 9'h080, "car1_rev_right");
    drive(332, 128, 1'b1, 9'h000, "car1_right_out");
    drive(299, 128, 1'b1, 9'h000, "car1_left_out");
    drive(305, 130, 1'b1, 9'h0DA, "car1_rev_mid");
    drive(300, 159, 1'b1, 9'h0FF, "car1_bottom_row");
    drive(300, 160, 1'b1, 9'h000, "car1_below");
    drive(0,   64,  1'b1, 9'h1C0, "frog_over_car");
    drive(3,   80,  1'b1, 9'h083, "frog_key_shows_car");
    drive(2,   66,  1'b1, 9'h1D2, "frog_opaque_on_car");

    // Mid-frame position change is ignored until the next capture.
    drive(200, 240, 1'b1, 9'h000, "midframe_bg");
    car_x = {10'd0, 10'd0, 10'd400, 10'd0};
    drive(300, 128, 1'b1, 9'h09F, "midframe_old_x");
    drive(400, 128, 1'b1, 9'h000, "midframe_new_x_bg");
    drive(0,   480, 1'b0, 9'h000, "capture3");
    drive(300, 128, 1'b1, 9'h000, "newframe_old_x_bg");
    drive(400, 128, 1'b1, 9'h09F, "newframe_new_x");

    // Blanking region and last visible pixel.
    drive(640, 10,  1'b0, 9'h000, "hblank_640");
    drive(799, 200, 1'b0, 9'h000, "hblank_799");
    drive(100, 480, 1'b0, 9'h000, "vblank_480");
    drive(5,   500, 1'b0, 9'h000, "vblank_500");
    drive(639, 479, 1'b1, 9'h000, "last_visible");

    // Asynchronous reset while a frog pixel is on the outputs.
    repeat (3) drive(0, 64, 1'b1, 9'h1C0, "hold_frog");
    drain();
    @(posedge clk);
    #2;
    check("pre_reset_frog", dut_out, {1'b1, 9'h1C0});
    rst = 1'b1;
    #1;
    check("reset_async", dut_out, 10'h000);
    @(negedge clk);
    rst = 1'b0;
    drive(0,   64,  1'b1, 9'h000, "post_reset_bg");
    drive(300, 128, 1'b1, 9'h000, "post_reset_car_bg");
    drive(0,   480, 1'b0, 9'h000, "capture4");
    drive(0,   64,  1'b1, 9'h1C0, "rearmed_frog");
    drive(400, 128, 1'b1, 9'h09F, "rearmed_car");
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
